// File: rtl/arb_grant_lock_bcd.sv
// Wormhole grant lock for an external combinational round-robin arbiter.
// In IDLE the arbiter's binary winner is captured when it names a live requester.
// The grant then stays locked until the granted input's tail flit transfers.
// On release, low_pr is updated with the retired winner to rotate priority.
// pkt_count counts completed packets and saturates at all-ones.
module arb_grant_lock_bcd #(
  parameter int unsigned ARBITER_WIDTH = 4,
  parameter int unsigned BCD_WIDTH     = 2,
  parameter int unsigned PKT_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ARBITER_WIDTH-1:0] request,
  input  logic [ARBITER_WIDTH-1:0] tail_flit,
  input  logic [BCD_WIDTH-1:0]     bcd_grant,
  input  logic                     out_ready,
  output logic [BCD_WIDTH-1:0]     low_pr,
  output logic                     grant_valid,
  output logic [BCD_WIDTH-1:0]     grant_bcd,
  output logic [ARBITER_WIDTH-1:0] grant_onehot,
  output logic                     xfer,
  output logic [PKT_CNT_WIDTH-1:0] pkt_count
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                   state_q, state_d;
  logic                     grant_valid_q, grant_valid_d;
  logic [BCD_WIDTH-1:0]     grant_bcd_q, grant_bcd_d;
  logic [ARBITER_WIDTH-1:0] grant_onehot_q, grant_onehot_d;
  logic [BCD_WIDTH-1:0]     low_pr_q, low_pr_d;
  logic [PKT_CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

  logic                     grant_hit;
  logic                     release_pkt;
  logic [ARBITER_WIDTH-1:0] cap_onehot;

  // Decode the arbiter's index; out-of-range indices decode to all-zero.
  always_comb begin
    cap_onehot = '0;
    for (int unsigned i = 0; i < ARBITER_WIDTH; i++) begin
      cap_onehot[i] = (32'(bcd_grant) == i);
    end
  end

  // Qualify the arbiter's pick, detect a flit transfer, and the tail-flit release.
  always_comb begin
    grant_hit   = (32'(bcd_grant) < ARBITER_WIDTH) && request[bcd_grant];
    xfer        = grant_valid_q & out_ready & request[grant_bcd_q];
    release_pkt = (state_q == StLocked) & xfer & tail_flit[grant_bcd_q];
  end

  // Next-state: capture in IDLE, hold while locked, release on the granted tail flit.
  always_comb begin
    state_d        = state_q;
    grant_valid_d  = grant_valid_q;
    grant_bcd_d    = grant_bcd_q;
    grant_onehot_d = grant_onehot_q;
    low_pr_d       = low_pr_q;
    pkt_count_d    = pkt_count_q;
    unique case (state_q)
      StIdle: begin
        if (grant_hit) begin
          state_d        = StLocked;
          grant_valid_d  = 1'b1;
          grant_bcd_d    = bcd_grant;
          grant_onehot_d = cap_onehot;
        end
      end
      StLocked: begin
        // Releasing returns to IDLE; the next capture waits a full cycle (bubble).
        if (release_pkt) begin
          state_d        = StIdle;
          grant_valid_d  = 1'b0;
          grant_onehot_d = '0;
          low_pr_d       = grant_bcd_q;
          if (pkt_count_q != '1) begin
            pkt_count_d = pkt_count_q + PKT_CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset overrides everything, abandoning any lock without counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      grant_valid_q  <= 1'b0;
      grant_bcd_q    <= '0;
      grant_onehot_q <= '0;
      low_pr_q       <= BCD_WIDTH'(ARBITER_WIDTH - 1);
      pkt_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      grant_valid_q  <= grant_valid_d;
      grant_bcd_q    <= grant_bcd_d;
      grant_onehot_q <= grant_onehot_d;
      low_pr_q       <= low_pr_d;
      pkt_count_q    <= pkt_count_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_bcd    = grant_bcd_q;
  assign grant_onehot = grant_onehot_q;
  assign low_pr       = low_pr_q;
  assign pkt_count    = pkt_count_q;

endmodule
